// File: rtl/psum_norm_unit.sv
// Psum row storage with an in-place normalisation engine. Each lane of a row is divided
// by the row's sum of absolute values. That sum can optionally be combined with a peer core's sum.
module psum_norm_unit #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 20,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int SUM_W   = 24,
    parameter int FRAC    = 8,
    parameter int EXT_SUM = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [COL*BW_PSUM-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [COL*BW_PSUM-1:0] rd_data,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [AW:0]            num_rows,
    output logic                   busy,
    output logic                   done,
    output logic [SUM_W-1:0]       sum_out,
    output logic                   sum_out_valid,
    input  logic [SUM_W-1:0]       sum_in,
    input  logic                   sum_in_valid
);

    localparam int LW = (COL > 1) ? $clog2(COL) : 1;
    localparam int NW = BW_PSUM + FRAC;
    localparam int DW = (NW > SUM_W) ? NW : SUM_W;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_ACC, S_XCHG, S_DIV, S_WB, S_DONE
    } state_t;

    state_t state, next_state;

    logic [COL*BW_PSUM-1:0] mem [DEPTH];
    logic [BW_PSUM-1:0]     lane [COL];
    logic [BW_PSUM-1:0]     lane_abs [COL];
    logic [BW_PSUM-1:0]     res [COL];
    logic [COL*BW_PSUM-1:0] res_row;
    logic [AW-1:0]          ptr;
    logic [AW:0]            count;
    logic [LW-1:0]          div_idx;
    logic [SUM_W-1:0]       total;
    logic [SUM_W-1:0]       local_sum;
    logic [SUM_W:0]         ext_total;
    logic [DW-1:0]          div_num;
    logic [BW_PSUM-1:0]     div_mag;
    logic [BW_PSUM-1:0]     div_res;
    logic                   div_neg;

    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign done          = (state == S_DONE);
    assign sum_out_valid = (state == S_XCHG);

    // Magnitudes are unsigned, so the most negative lane value maps to 2^(BW_PSUM-1) without overflow.
    always_comb begin
        local_sum = '0;
        for (int k = 0; k < COL; k++) begin
            lane_abs[k] = lane[k][BW_PSUM-1] ? (~lane[k] + 1'b1) : lane[k];
            local_sum   = local_sum + SUM_W'(lane_abs[k]);
        end
    end

    always_comb begin
        res_row = '0;
        for (int k = 0; k < COL; k++) begin
            res_row[k*BW_PSUM +: BW_PSUM] = res[k];
        end
    end

    // Single shared divider that processes one lane per cycle.
    // A zero total only happens when the row is all zeros, so the result is forced to 0.
    always_comb begin
        div_num = DW'(lane_abs[div_idx]) << FRAC;
        div_neg = lane[div_idx][BW_PSUM-1];
        div_mag = '0;
        if (total != '0) begin
            div_mag = BW_PSUM'(div_num / DW'(total));
        end
        div_res = div_neg ? (~div_mag + 1'b1) : div_mag;
    end

    assign ext_total = {1'b0, total} + {1'b0, sum_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (num_rows == '0) ? S_DONE : S_READ;
            S_READ:  next_state = S_ACC;
            S_ACC:   next_state = (EXT_SUM != 0) ? S_XCHG : S_DIV;
            S_XCHG:  if (sum_in_valid) next_state = S_DIV;
            S_DIV:   if (div_idx == LW'(COL - 1)) next_state = S_WB;
            S_WB:    next_state = (count == (AW+1)'(1)) ? S_DONE : S_READ;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            sum_out <= '0;
            ptr     <= '0;
            count   <= '0;
            div_idx <= '0;
            total   <= '0;
            for (int k = 0; k < COL; k++) begin
                lane[k] <= '0;
                res[k]  <= '0;
            end
        end else begin
            if (rd_en && !busy) begin
                rd_data <= mem[rd_addr];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr   <= base_addr;
                        count <= num_rows;
                    end
                end
                S_READ: begin
                    for (int k = 0; k < COL; k++) begin
                        lane[k] <= mem[ptr][k*BW_PSUM +: BW_PSUM];
                    end
                    div_idx <= '0;
                end
                S_ACC: begin
                    total <= local_sum;
                    if (EXT_SUM != 0) begin
                        sum_out <= local_sum;
                    end
                end
                S_XCHG: begin
                    if (sum_in_valid) begin
                        total <= ext_total[SUM_W] ? '1 : ext_total[SUM_W-1:0];
                    end
                end
                S_DIV: begin
                    res[div_idx] <= div_res;
                    div_idx      <= div_idx + 1'b1;
                end
                S_WB: begin
                    ptr   <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset. The engine's write-back and host writes never coincide because busy gates the host.
    always_ff @(posedge clk) begin
        if (state == S_WB) begin
            mem[ptr] <= res_row;
        end else if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_psum_norm_unit.sv
// Self-checking bench for psum_norm_unit. It instantiates one core with local sums only
// and one core that exchanges sums with a peer.
module tb_psum_norm_unit;

    localparam int COL   = 8;
    localparam int BW    = 20;
    localparam int ROW_W = COL * BW;

    logic             clk = 0;
    logic             reset = 0;
    logic             wr_en = 0;
    logic [3:0]       wr_addr = '0;
    logic [ROW_W-1:0] wr_data = '0;
    logic             rd_en = 0;
    logic [3:0]       rd_addr = '0;
    logic [3:0]       base_addr = '0;
    logic [4:0]       num_rows = '0;
    logic             start0 = 0, start1 = 0;
    logic [23:0]      sum_in = '0;
    logic             sum_in_valid = 0;

    logic [ROW_W-1:0] rd_data0, rd_data1;
    logic             busy0, busy1, done0, done1;
    logic [23:0]      sum_out0, sum_out1;
    logic             sum_out_valid0, sum_out_valid1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               addr;
        logic [ROW_W-1:0] in_row;
        logic [ROW_W-1:0] exp_row;
        string            name;
    } vec_t;
    vec_t vecs [10];

    typedef struct {
        bit               sel;
        logic [ROW_W-1:0] exp;
        string            name;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_cur;
    bit  sb_req = 0;
    bit  sb_pend = 0;

    psum_norm_unit #(.EXT_SUM(0)) dut0 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .start(start0), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy0), .done(done0),
        .sum_out(sum_out0), .sum_out_valid(sum_out_valid0),
        .sum_in(sum_in), .sum_in_valid(sum_in_valid)
    );

    psum_norm_unit #(.EXT_SUM(1)) dut1 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .start(start1), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy1), .done(done1),
        .sum_out(sum_out1), .sum_out_valid(sum_out_valid1),
        .sum_in(sum_in), .sum_in_valid(sum_in_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] packRow(input int l0, l1, l2, l3, l4, l5, l6, l7);
        int v [COL];
        logic [ROW_W-1:0] r;
        v = '{l0, l1, l2, l3, l4, l5, l6, l7};
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = v[k][BW-1:0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A read is issued at a negedge. Its data is compared at the following negedge against the queued expectation.
    always @(posedge clk) sb_pend <= sb_req;

    always @(negedge clk) begin
        if (sb_pend) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_empty: read data arrived with no expectation queued");
            end else begin
                sb_cur = sb_q.pop_front();
                checkOutput(sb_cur.name, sb_cur.sel ? rd_data1 : rd_data0, sb_cur.exp);
            end
        end
    end

    task automatic writeRow(input int addr, input logic [ROW_W-1:0] data);
        @(negedge clk);
        wr_en = 1; wr_addr = addr[3:0]; wr_data = data;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic readRow(input bit sel, input int addr, input logic [ROW_W-1:0] exp, input string name);
        @(negedge clk);
        rd_en = 1; rd_addr = addr[3:0]; sb_req = 1;
        sb_q.push_back('{sel: sel, exp: exp, name: name});
        @(negedge clk);
        rd_en = 0; sb_req = 0;
    endtask

    task automatic applyStimulus(input bit sel, input int base, input int n);
        @(negedge clk);
        base_addr = base[3:0];
        num_rows  = n[4:0];
        if (sel) start1 = 1; else start0 = 1;
        @(negedge clk);
        start0 = 0; start1 = 0;
    endtask

    task automatic waitDone(input bit sel, input string name, input int bound);
        bit seen;
        seen = 0;
        for (int c = 0; c < bound; c++) begin
            if (sel ? done1 : done0) begin seen = 1; break; end
            @(negedge clk);
        end
        checkOutput({name, "_done"}, ROW_W'(seen), ROW_W'(1));
    endtask

    task automatic runBlock(input bit sel, input int base, input int n, input int exp_busy, input string name);
        int busy_cyc;
        bit seen;
        busy_cyc = 0;
        seen = 0;
        applyStimulus(sel, base, n);
        for (int c = 0; c < 400; c++) begin
            if (sel ? done1 : done0) begin seen = 1; break; end
            if (sel ? busy1 : busy0) busy_cyc++;
            @(negedge clk);
        end
        checkOutput({name, "_done"}, ROW_W'(seen), ROW_W'(1));
        checkOutput({name, "_busy_cycles"}, ROW_W'(busy_cyc), ROW_W'(exp_busy));
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, ROW_W'(sel ? done1 : done0), '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ROW_W-1:0] raw13, r1, r2, r3;

        vecs[0] = '{3,  packRow(1, -1, 2, 0, 0, 0, 0, 4),       packRow(32, -32, 64, 0, 0, 0, 0, 128), "basic"};
        vecs[1] = '{5,  packRow(0, 0, 0, 0, 0, 0, 0, 0),        packRow(0, 0, 0, 0, 0, 0, 0, 0),       "zero_row"};
        vecs[2] = '{7,  packRow(-524288, 0, 0, 0, 0, 0, 0, 0),  packRow(-256, 0, 0, 0, 0, 0, 0, 0),    "min_lane"};
        vecs[3] = '{9,  packRow(3, 0, 0, 0, 0, 0, 0, 0),        packRow(256, 0, 0, 0, 0, 0, 0, 0),     "single_pos"};
        vecs[4] = '{2,  packRow(1, 1, 1, 0, 0, 0, 0, 0),        packRow(85, 85, 85, 0, 0, 0, 0, 0),    "trunc3"};
        vecs[5] = '{4,  packRow(-5, 10, 0, 0, 0, 0, 0, 5),      packRow(-64, 128, 0, 0, 0, 0, 0, 64),  "mixed"};
        vecs[6] = '{6,  packRow(7, -3, 0, 0, 0, 0, 0, 0),       packRow(179, -76, 0, 0, 0, 0, 0, 0),   "trunc_neg"};
        vecs[7] = '{10, packRow(100000, -100000, 200000, -200000, 0, 0, 0, 0),
                        packRow(42, -42, 85, -85, 0, 0, 0, 0), "large"};
        vecs[8] = '{11, packRow(524287, 524287, 524287, 524287, 524287, 524287, 524287, 524287),
                        packRow(32, 32, 32, 32, 32, 32, 32, 32), "max_pos"};
        vecs[9] = '{12, packRow(-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288),
                        packRow(-32, -32, -32, -32, -32, -32, -32, -32), "all_min"};

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", ROW_W'(busy0), '0);
        checkOutput("reset_done", ROW_W'(done0), '0);
        checkOutput("reset_rd_data", rd_data0, '0);
        checkOutput("reset_sum_out", ROW_W'(sum_out1), '0);
        checkOutput("reset_sum_out_valid", ROW_W'(sum_out_valid1), '0);
        reset = 1;

        for (int i = 0; i < 10; i++) begin
            writeRow(vecs[i].addr, vecs[i].in_row);
            runBlock(0, vecs[i].addr, 1, 11, vecs[i].name);
            readRow(0, vecs[i].addr, vecs[i].exp_row, {vecs[i].name, "_row"});
        end

        // Two rows starting at the top of storage wrap to row 0. Row 1 must stay untouched.
        writeRow(15, packRow(2, 0, 0, 0, 0, 0, 0, 2));
        writeRow(0,  packRow(0, 4, 0, 0, 0, 0, 0, 0));
        writeRow(1,  packRow(1, 0, 0, 0, 0, 0, 0, 0));
        runBlock(0, 15, 2, 22, "wrap");
        readRow(0, 15, packRow(128, 0, 0, 0, 0, 0, 0, 128), "wrap_row15");
        readRow(0, 0,  packRow(0, 256, 0, 0, 0, 0, 0, 0), "wrap_row0");
        readRow(0, 1,  packRow(1, 0, 0, 0, 0, 0, 0, 0), "wrap_row1");

        runBlock(0, 4, 0, 0, "zero_rows");

        // While the engine is busy, a host write, a host read and a second start must all have no effect.
        raw13 = packRow(5, 6, 7, 8, 9, 10, 11, 12);
        writeRow(8, packRow(8, 0, 0, 0, 0, 0, 0, 0));
        writeRow(13, raw13);
        readRow(0, 13, raw13, "ign_pre_read");
        applyStimulus(0, 8, 1);
        wr_en = 1; wr_addr = 4'd13; wr_data = packRow(-1, -1, -1, -1, -1, -1, -1, -1);
        rd_en = 1; rd_addr = 4'd8;
        start0 = 1; base_addr = 4'd13; num_rows = 5'd1;
        @(negedge clk);
        wr_en = 0; rd_en = 0; start0 = 0;
        waitDone(0, "ign", 40);
        checkOutput("ign_rd_hold", rd_data0, raw13);
        repeat (3) @(negedge clk);
        checkOutput("ign_restart", ROW_W'(busy0), '0);
        readRow(0, 13, raw13, "ign_row13");
        readRow(0, 8, packRow(256, 0, 0, 0, 0, 0, 0, 0), "ign_row8");

        // The peer sum arrives three cycles late. sum_out must hold the local sum until the peer sum is accepted.
        writeRow(3, packRow(1, -1, 2, 0, 0, 0, 0, 4));
        applyStimulus(1, 3, 1);
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (sum_out_valid1) begin seen = 1; break; end
                @(negedge clk);
            end
            checkOutput("xchg_valid", ROW_W'(seen), ROW_W'(1));
        end
        checkOutput("xchg_sum_out", ROW_W'(sum_out1), ROW_W'(8));
        repeat (3) @(negedge clk);
        checkOutput("xchg_hold", ROW_W'(sum_out_valid1), ROW_W'(1));
        sum_in = 24'd8; sum_in_valid = 1;
        @(negedge clk);
        sum_in_valid = 0;
        checkOutput("xchg_release", ROW_W'(sum_out_valid1), '0);
        waitDone(1, "xchg", 40);
        readRow(1, 3, packRow(16, -16, 32, 0, 0, 0, 0, 64), "xchg_row3");

        // A peer sum that would overflow the combined total must saturate it, so every quotient becomes 0.
        writeRow(14, packRow(4, 0, 0, 0, 0, 0, 0, 4));
        sum_in = 24'hFFFFFC; sum_in_valid = 1;
        runBlock(1, 14, 1, 12, "sat");
        sum_in_valid = 0;
        readRow(1, 14, packRow(0, 0, 0, 0, 0, 0, 0, 0), "sat_row14");

        // Assert reset during the divide phase of row 2 in a three-row block.
        r1 = packRow(1, -1, 2, 0, 0, 0, 0, 4);
        r2 = packRow(3, 0, 0, 0, 0, 0, 0, 0);
        r3 = packRow(0, 5, 0, 0, 0, 0, 0, 0);
        writeRow(1, r1);
        writeRow(2, r2);
        writeRow(3, r3);
        applyStimulus(0, 1, 3);
        repeat (14) @(negedge clk);
        checkOutput("midrst_busy_before", ROW_W'(busy0), ROW_W'(1));
        reset = 0;
        #1;
        checkOutput("midrst_busy", ROW_W'(busy0), '0);
        checkOutput("midrst_done", ROW_W'(done0), '0);
        @(negedge clk);
        reset = 1;
        checkOutput("midrst_rd_data", rd_data0, '0);
        readRow(0, 1, packRow(32, -32, 64, 0, 0, 0, 0, 128), "midrst_row1");
        readRow(0, 2, r2, "midrst_row2");
        readRow(0, 3, r3, "midrst_row3");

        repeat (2) @(negedge clk);
        checkOutput("sb_drain", ROW_W'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
